// File: rtl/dpram_stream_reader.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader
//
// Read-side client for a dual-port RAM port with 1-cycle registered read
// latency. A start command fetches `length` consecutive words beginning at
// `base_addr` (address wraps modulo 2**ADDR_W). The words are delivered on a
// valid/ready stream through a 4-entry prefetch FIFO. This sustains one word
// per cycle and absorbs backpressure without losing words.
//
// Optional feature: define DPRAM_READER_LOOP_EN to add the `loop` input.
// The value of `loop` at an accepted start enables looping. While looping is
// enabled, the command replays its address range pass after pass. Each pass
// end is still marked by out_last. Once `loop` drops, the current pass
// completes, followed by the done pulse.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               command strobe (ignored unless idle)
//   base_addr, length   command parameters, captured on accepted start
//   loop                (DPRAM_READER_LOOP_EN only) replay command passes
//   busy, done          command status; done is a one-cycle pulse
//   ram_address         RAM read address (holds last issued address)
//   ram_byteena         tied 1
//   ram_wren            tied 0
//   ram_q               RAM read data, valid the cycle after the address
//   out_data, out_valid, out_ready, out_last   output stream
// -----------------------------------------------------------------------------
module dpram_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
`ifdef DPRAM_READER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_byteena,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   words_left;
  logic              inflight;
  logic              loop_active;

  logic [DATA_W-1:0] fifo_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_count;
  logic [2:0]        occupancy;

  logic issue;
  logic push;
  logic pop;

`ifdef DPRAM_READER_LOOP_EN
  logic [ADDR_W-1:0] cap_base;
  logic [ADDR_W:0]   cap_length;
`else
  assign loop_active = 1'b0;
`endif

  // Issue only when a slot is reserved for the returning word. Counting the
  // in-flight read makes FIFO overflow impossible.
  assign occupancy = fifo_count + {2'b00, inflight};
  assign issue     = (state == RUN) && (issue_left != '0) && (occupancy < 3'd4);
  assign push      = inflight;
  assign pop       = out_valid && out_ready;

  assign ram_address = issue ? rd_addr : addr_hold;
  assign ram_byteena = 1'b1;
  assign ram_wren    = 1'b0;

  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last  = out_valid && (words_left == LEN_ONE);

  // NOTE: the FIFO storage has no reset. Only pointers and count are reset;
  // out_data is masked while the FIFO is empty, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

  // NOTE: state is updated with non-blocking assignments only. Later
  // assignments in this block (FIN flush) override earlier ones in the
  // same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
      addr_hold  <= '0;
      issue_left <= '0;
      words_left <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
`ifdef DPRAM_READER_LOOP_EN
      loop_active <= 1'b0;
      cap_base    <= '0;
      cap_length  <= '0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        addr_hold <= rd_addr;
`ifdef DPRAM_READER_LOOP_EN
        if (loop_active && issue_left == LEN_ONE) begin
          issue_left <= cap_length;
          rd_addr    <= cap_base;
        end else begin
          issue_left <= issue_left - 1'b1;
          rd_addr    <= rd_addr + 1'b1;
        end
`else
        issue_left <= issue_left - 1'b1;
        // Natural ADDR_W-bit overflow gives the modulo-RAM-size wrap.
        rd_addr    <= rd_addr + 1'b1;
`endif
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
`ifdef DPRAM_READER_LOOP_EN
            loop_active <= loop;
            cap_base    <= base_addr;
            cap_length  <= length;
`endif
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= RUN;
              busy       <= 1'b1;
              rd_addr    <= base_addr;
              issue_left <= length;
              words_left <= length;
            end
          end
        end
        RUN: begin
`ifdef DPRAM_READER_LOOP_EN
          if (!loop) loop_active <= 1'b0;
`endif
          if (pop) begin
            if (words_left == LEN_ONE) begin
              if (loop_active) begin
`ifdef DPRAM_READER_LOOP_EN
                words_left <= cap_length;
`endif
              end else begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              words_left <= words_left - 1'b1;
            end
          end
        end
        FIN: begin
          // Discard words prefetched for a pass that will not be delivered.
          state      <= IDLE;
          inflight   <= 1'b0;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          fifo_count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Read-side client for the team's dual-port RAM models: one port with 1-cycle registered read latency, read-during-write returns new data.
- On a start command, fetches LENGTH consecutive words from BASE_ADDR, wrapping modulo RAM size.
- Delivers words on a valid/ready stream with full 1-word/cycle throughput and lossless backpressure, using a 4-entry prefetch FIFO.
- Sits between a RAM port (e.g. line/frame buffer filled by a writer on the other port) and a pixel/sample consumer.

Parameters:
- ADDR_W, 8, RAM address width; RAM holds 2**ADDR_W words.
- DATA_W, 8, RAM word width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, captured on accepted start.
- length  in  ADDR_W+1  word count 0..2**ADDR_W, captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of command.
- ram_address  out  ADDR_W  read address to RAM port.
- ram_byteena  out  1  tied 1.
- ram_wren  out  1  tied 0; this block never writes.
- ram_q  in  DATA_W  RAM read data, valid the cycle after its address is presented.
- out_data  out  DATA_W  stream word, driven from FIFO head.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready; transfer when out_valid && out_ready.
- out_last  out  1  high with the final word of a command.

Behaviour:
- Reset: state IDLE; busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_address=0; FIFO empty; in-flight flag cleared. Reset mid-command abandons it; no done pulse.
- States:
  - IDLE: start=1 captures base_addr, length. length=0 goes to FIN. Otherwise goes to RUN with rd_addr=base_addr, issue_left=length, words_left=length.
  - RUN: issue a read in a cycle when issue_left>0 and fifo_count+inflight<4. Issue means ram_address=rd_addr this cycle; rd_addr+1 wraps 2**ADDR_W-1 to 0; issue_left-1; inflight=1 next cycle. When inflight=1, ram_q is pushed into the FIFO at the end of the cycle. Each stream handshake pops the FIFO and decrements words_left. The handshake with words_left=1 goes to FIN.
  - FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- busy=1 in RUN; 0 in IDLE and FIN.
- start while not IDLE: ignored, no side effect.
- Timing: start sampled at edge 0 → base_addr on ram_address in cycle 1 → ram_q in cycle 2 → out_valid=1 in cycle 3.
- Throughput: with out_ready held 1, one word per cycle after the first.
- ram_address holds its last issued value when not issuing.
- Backpressure: with out_ready=0, at most 4 words are buffered and reads stall. No word is ever dropped or duplicated. The FIFO never overflows, because a push only follows an issue made when fifo_count+inflight<4.
- out_data and out_valid are stable while out_valid && !out_ready.
- out_last=1 exactly when the head word is the last word (words_left=1).
- Simultaneous push and pop: count unchanged, order preserved.
- length=2**ADDR_W reads every word once, starting at base_addr and wrapping.

Optional Feature:
- Macro DPRAM_READER_LOOP_EN.
- Defined: adds input port loop (1 bit), sampled on accepted start. With loop=1, issue_left and rd_addr reload from the captured length and base on exhaustion. out_last still marks each pass end. done and FIN are never reached until loop is deasserted, at which point the current pass completes normally. length=0 with loop=1 behaves as length=0.
- Undefined: no loop port; one pass per start.

Test Plan:
- RAM preloaded mem[i]=i; base=0x10, length=4, out_ready=1 → out_data 0x10,0x11,0x12,0x13 on consecutive cycles, first valid 3 cycles after start, out_last on 0x13, done 1 cycle later.
- base=0xFE, length=4 → stream 0xFE,0xFF,0x00,0x01; ram_address wraps to 0x00.
- length=8, out_ready=0 for 10 cycles then 1 → exactly 4 words buffered with reads stalled during stall; then all 8 words in order with no duplicates; out_data stable while stalled.
- length=0 → done pulse 1 cycle after start, no reads issued, out_valid stays 0.
- start pulsed again mid-command, and reset_n pulled low after 2 of 6 words → second start ignored; after reset all outputs 0, FIFO empty, no done pulse.
- LOOP_EN build: base=0x20, length=2, loop=1 → 0x20,0x21,0x20,0x21,…; out_last on each 0x21; loop dropped → finishes current pass, then done.
